// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding,
// default widths and the debug starvation limit.
package dmem_arb_pkg;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 8;
    localparam int MAX_WAIT_DEF = 4;

    // Owner of the memory during the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // 8-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = val;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter with synchronous clear. sat_o flags that the
// count has reached LIMIT, at which point the waiting side is forced through.
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CW    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sat_s;

    assign sat_s = (cnt_q == LIMIT_C);
    assign sat_o = sat_s;

    // Next count: clear wins, otherwise count up until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_s) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-ported data memory between the core load/store
// path (fixed priority) and the debug/program-loader port. Debug progress is
// guaranteed by a starvation counter and by a burst lock that is honoured
// only while debug already owns the memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    stall_cnt
);

    owner_e        owner_q;
    owner_e        owner_d;
    logic          starve_sat_s;
    logic          starve_inc_s;
    logic          dbg_sel_s;
    logic [DW-1:0] dbg_rdata_q;
    logic          dbg_valid_q;
    logic [7:0]    stall_cnt_q;

    // Debug wins when the core is quiet, when it has waited MAX_WAIT cycles,
    // or when it already owns and holds the lock. Reset blocks every grant.
    assign dbg_sel_s = rst_n & dbg_req &
                       (~core_req | starve_sat_s |
                        ((owner_q == OWN_DBG) & dbg_lock));

    assign starve_inc_s = dbg_req & ~dbg_sel_s;

    arb_starve_counter #(
        .LIMIT (MAX_WAIT),
        .CW    (4)
    ) u_starve (
        .clk_i  (CLK),
        .rst_ni (rst_n),
        .inc_i  (starve_inc_s),
        .clr_i  (~starve_inc_s),
        .sat_o  (starve_sat_s)
    );

    // Owner register: remembers who used the memory last cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Next owner follows this cycle's grant.
    always_comb begin
        owner_d = OWN_IDLE;
        if (dbg_sel_s) begin
            owner_d = OWN_DBG;
        end else if (rst_n && core_req) begin
            owner_d = OWN_CORE;
        end else begin
            owner_d = OWN_IDLE;
        end
    end

    // Grants, stall and memory mux; idle bus drives zeros so no stray write.
    always_comb begin
        dbg_gnt    = dbg_sel_s;
        core_gnt   = rst_n & core_req & ~dbg_sel_s;
        core_stall = core_req & ~core_gnt;
        core_rdata = mem_rdata;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (dbg_sel_s) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Debug read capture, valid pulse and saturating stall counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_q <= '0;
            dbg_valid_q <= 1'b0;
            stall_cnt_q <= 8'd0;
        end else begin
            if (dbg_sel_s && !dbg_we) begin
                dbg_rdata_q <= mem_rdata;
                dbg_valid_q <= 1'b1;
            end else begin
                dbg_valid_q <= 1'b0;
            end
            if (core_stall) begin
                stall_cnt_q <= sat_inc8(stall_cnt_q);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign dbg_rdata = dbg_rdata_q;
    assign dbg_valid = dbg_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 memory.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b1;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = 8'h00, core_wdata = 8'h00;
    logic       core_gnt, core_stall;
    logic [7:0] core_rdata;
    logic       dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [7:0] dbg_addr = 8'h00, dbg_wdata = 8'h00;
    logic       dbg_gnt, dbg_valid;
    logic [7:0] dbg_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] stall_cnt;

    logic [7:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    dmem_arbiter dut (
        .CLK(CLK), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
        check_eq("rst_dbg_valid", 32'(dbg_valid), 32'h0);
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #3;
        check_eq("idle_core_gnt", 32'(core_gnt), 32'h0);
        check_eq("idle_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check_eq("idle_mem_we", 32'(mem_we), 32'h0);
        check_eq("idle_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("idle_core_stall", 32'(core_stall), 32'h0);
        tick();

        // Core-only store then load back
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hA5;
        #3;
        check_eq("cst_core_gnt", 32'(core_gnt), 32'h1);
        check_eq("cst_mem_we", 32'(mem_we), 32'h1);
        check_eq("cst_mem_addr", 32'(mem_addr), 32'h10);
        check_eq("cst_mem_wdata", 32'(mem_wdata), 32'hA5);
        check_eq("cst_core_stall", 32'(core_stall), 32'h0);
        tick();
        core_we = 1'b0;
        #3;
        check_eq("cld_core_rdata", 32'(core_rdata), 32'hA5);
        check_eq("cld_mem_we", 32'(mem_we), 32'h0);
        tick();
        core_req = 1'b0;
        check_eq("cst_stall_cnt", 32'(stall_cnt), 32'h0);

        // Debug write 3C to 20, then debug read of 20
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
        #3;
        check_eq("dwr_dbg_gnt", 32'(dbg_gnt), 32'h1);
        check_eq("dwr_mem_we", 32'(mem_we), 32'h1);
        tick();
        check_eq("dwr_no_valid", 32'(dbg_valid), 32'h0);
        dbg_we = 1'b0;
        #3;
        check_eq("drd_dbg_gnt", 32'(dbg_gnt), 32'h1);
        check_eq("drd_core_gnt", 32'(core_gnt), 32'h0);
        check_eq("drd_mem_we", 32'(mem_we), 32'h0);
        check_eq("drd_mem_addr", 32'(mem_addr), 32'h20);
        tick();
        dbg_req = 1'b0;
        check_eq("drd_valid1", 32'(dbg_valid), 32'h1);
        check_eq("drd_rdata1", 32'(dbg_rdata), 32'h3C);
        tick();
        check_eq("drd_valid0", 32'(dbg_valid), 32'h0);
        check_eq("drd_rdata_hold", 32'(dbg_rdata), 32'h3C);
        tick();

        // Contention: core wins 4 cycles, debug forced in cycle 4, core in 5
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 8'h77;
        for (int k = 0; k < 6; k++) begin
            #3;
            check_eq($sformatf("cont_core_gnt_%0d", k), 32'(core_gnt), (k == 4) ? 32'h0 : 32'h1);
            check_eq($sformatf("cont_dbg_gnt_%0d", k), 32'(dbg_gnt), (k == 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("cont_stall_%0d", k), 32'(core_stall), (k == 4) ? 32'h1 : 32'h0);
            tick();
        end
        check_eq("cont_stall_cnt", 32'(stall_cnt), 32'h1);
        check_eq("cont_mem40", 32'(mem[8'h40]), 32'h77);

        // Burst: lock held from the start is ignored until the forced grant
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_lock = 1'b1; dbg_addr = 8'h50;
        for (int k = 0; k < 11; k++) begin
            dbg_wdata = 8'(k);
            #3;
            check_eq($sformatf("burst_dbg_gnt_%0d", k), 32'(dbg_gnt), (k >= 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("burst_core_gnt_%0d", k), 32'(core_gnt), (k >= 4) ? 32'h0 : 32'h1);
            check_eq($sformatf("burst_stall_%0d", k), 32'(core_stall), (k >= 4) ? 32'h1 : 32'h0);
            tick();
        end
        check_eq("burst_stall_cnt", 32'(stall_cnt), 32'h8);
        dbg_req = 1'b0;
        #3;
        check_eq("burst_drop_core_gnt", 32'(core_gnt), 32'h1);
        check_eq("burst_drop_dbg_gnt", 32'(dbg_gnt), 32'h0);
        tick();
        check_eq("burst_mem50", 32'(mem[8'h50]), 32'h0A);

        // Async reset in the middle of a locked debug write
        core_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 8'h60; dbg_wdata = 8'h11;
        #3;
        check_eq("rstm_first_gnt", 32'(dbg_gnt), 32'h1);
        tick();
        core_req = 1'b1; dbg_wdata = 8'h22;
        #3;
        check_eq("rstm_lock_gnt", 32'(dbg_gnt), 32'h1);
        check_eq("rstm_lock_we", 32'(mem_we), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstm_mem_we", 32'(mem_we), 32'h0);
        check_eq("rstm_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check_eq("rstm_core_gnt", 32'(core_gnt), 32'h0);
        check_eq("rstm_valid", 32'(dbg_valid), 32'h0);
        check_eq("rstm_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        check_eq("rstm_mem60", 32'(mem[8'h60]), 32'h11);
        #3;
        check_eq("rstm_owner_idle_core", 32'(core_gnt), 32'h1);
        check_eq("rstm_owner_idle_dbg", 32'(dbg_gnt), 32'h0);
        tick();
        check_eq("rstm_stall_cnt_after", 32'(stall_cnt), 32'h0);

        // Saturation: debug takes ownership, lock stalls the core 300 cycles
        core_req = 1'b0;
        #3;
        check_eq("sat_take_gnt", 32'(dbg_gnt), 32'h1);
        tick();
        core_req = 1'b1;
        #3;
        check_eq("sat_stall_on", 32'(core_stall), 32'h1);
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 254) check_eq("sat_254", 32'(stall_cnt), 32'hFE);
            if (n == 255) check_eq("sat_255", 32'(stall_cnt), 32'hFF);
        end
        check_eq("sat_300", 32'(stall_cnt), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 8-bit DataMemory between two requesters: the processor core (load/store path) and the debug/program-loader port.
- Core has fixed priority. A starvation counter and a debug burst lock guarantee progress for debug traffic.
- Sits between the core's ALUResult/WriteData/MemWrite nets and DataMemory. Drives a core stall when the core is denied.

Parameters:
AW, 8, address width (matches the 8-bit data memory).
DW, 8, data width.
MAX_WAIT, 4, consecutive denied debug cycles before debug is forced through (1..15).

Ports:
CLK  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
core_req  in  1  core wants memory this cycle (load or store).
core_we  in  1  core store.
core_addr  in  AW  core address (ALUResult).
core_wdata  in  DW  core store data.
core_gnt  out  1  core access performed this cycle (combinational).
core_stall  out  1  core_req & ~core_gnt; core must hold PC and inputs.
core_rdata  out  DW  mem_rdata passthrough, valid when core_gnt.
dbg_req  in  1  debug access request.
dbg_we  in  1  debug write.
dbg_lock  in  1  keep ownership for back-to-back debug accesses.
dbg_addr  in  AW  debug address.
dbg_wdata  in  DW  debug write data.
dbg_gnt  out  1  debug access performed this cycle (combinational).
dbg_rdata  out  DW  registered read data.
dbg_valid  out  1  one-cycle pulse, cycle after a granted debug read.
mem_we  out  1  to DataMemory MemWrite.
mem_addr  out  AW  to DataMemory address.
mem_wdata  out  DW  to DataMemory WriteData.
mem_rdata  in  DW  DataMemory ReadData (combinational read).
stall_cnt  out  8  saturating count of core stall cycles.

Behaviour:
- Reset values: owner=IDLE, starve=0, dbg_rdata=0, dbg_valid=0, stall_cnt=0.
  - With no requests, all combinational outputs are 0.
  - Reset mid-access aborts immediately; no write issues while rst_n=0. All grants are forced to 0 during reset.
- State register owner ∈ {IDLE, CORE, DBG} records the last cycle's grantee. It becomes IDLE when neither is granted.
- Debug select is combinational: dbg_sel = dbg_req & (~core_req | starve==MAX_WAIT | (owner==DBG & dbg_lock)).
- Grants: dbg_gnt=dbg_sel; core_gnt=core_req & ~dbg_sel. At most one grant per cycle.
- Memory mux:
  - dbg_gnt → dbg_addr/dbg_wdata, mem_we=dbg_we.
  - core_gnt → core fields, mem_we=core_we.
  - No grant → addr/wdata 0, mem_we=0.
- Starvation counter:
  - dbg_req & ~dbg_gnt → starve+1, saturating at MAX_WAIT.
  - dbg_gnt or ~dbg_req → 0.
- Forced debug grant consumes exactly one cycle. The counter resets, so the core regains priority next cycle unless dbg_lock holds.
- Lock: once owner==DBG, dbg_lock=1 with dbg_req=1 keeps debug granted indefinitely, stalling the core.
  - Lock is honoured only if debug already owns. Asserting dbg_lock while owner≠DBG has no effect until a normal or forced grant.
- Debug read data:
  - On a granted debug read (dbg_gnt & ~dbg_we), dbg_rdata<=mem_rdata and dbg_valid<=1 on the next edge. Otherwise dbg_valid<=0.
  - dbg_rdata holds its value when not updated.
- Core read: core_rdata=mem_rdata combinationally, zero-latency, which single-cycle timing requires.
- Simultaneous requests to the same address: only the granted side accesses. The loser is retried by the requester; the arbiter does no buffering.
- stall_cnt increments on every core_stall cycle and saturates at 255.
- Requesters must hold req/addr/data stable until granted.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner state encoding (IDLE=2'd0, CORE=2'd1, DBG=2'd2);
  - AW/DW defaults;
  - MAX_WAIT default.
- One natural sub-module: arb_starve_counter (saturating counter with clear, parameterised limit, sat flag output).

Test Plan:
- Core-only store: core_req=1, we=1, addr=8'h10, wdata=8'hA5 → core_gnt=1, mem_we=1, mem_addr=8'h10, core_stall=0, stall_cnt stays 0.
- Debug-only read: memory[8'h20]=8'h3C; dbg_req=1, we=0, addr=8'h20 → dbg_gnt same cycle; next cycle dbg_valid=1 and dbg_rdata=8'h3C; dbg_valid=0 the cycle after.
- Contention with MAX_WAIT=4: core_req and dbg_req held high → core granted cycles 0–3, debug granted cycle 4, core granted again cycle 5; core_stall=1 only in cycle 4; stall_cnt=1.
- Debug burst: force a debug grant, then hold dbg_lock=1 and dbg_req=1 for 6 cycles with core_req=1 → dbg_gnt for all 6, core_stall=1 each cycle, stall_cnt=6; dropping dbg_req returns the grant to the core the same cycle.
- Async reset mid-burst: assert rst_n=0 between edges while a debug write is in progress → mem_we=0 and grants 0 immediately; owner=IDLE, dbg_valid=0, stall_cnt=0 after release.
- Saturation: hold core stalled via lock for 300 cycles → stall_cnt=8'hFF, no wrap.
